ifetch_queue: RTL and testbench

//  Decoupled, parametrised instruction-fetch stage. Owns the PC, issues one synchronous instr_mem

---
 rtl/ifetch_queue_pkg.sv | 23 ++
 rtl/ifetch_queue_fifo.sv | 82 ++++++++
 rtl/ifetch_queue_imem.sv | 43 ++++
 rtl/ifetch_queue.sv | 123 ++++++++++++
 tb/tb_ifetch_queue.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_queue_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : ifetch_queue_pkg
// Brief  : Shared widths, reset defaults and sizing helpers for the fetch queue.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
package ifetch_queue_pkg;

   localparam int unsigned DEF_WORD     = 32;
   localparam logic [31:0] DEF_RESET_PC = 32'd0;
   localparam logic [31:0] DEF_MEM_BASE = 32'hA000_0000;

   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // One extra bit so a completely full FIFO is distinguishable from empty.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ifetch_queue_fifo.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : ifetch_queue_fifo
// Brief  : Flat-register FIFO with synchronous clear, occupancy count, full/empty.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
module ifetch_queue_fifo
   import ifetch_queue_pkg::*;
#(
   parameter int unsigned WIDTH = 96,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     wr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned PW = ptr_width(DEPTH);
   localparam logic [$clog2(DEPTH):0] FULL_C = DEPTH[$clog2(DEPTH):0];

   logic [WIDTH-1:0]         mem_q [DEPTH];
   logic [WIDTH-1:0]         mem_d [DEPTH];
   logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
   logic [$clog2(DEPTH):0]   count_q, count_d;

   // Clear wins over any same-cycle write or read.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         case ({wr, rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign count   = count_q;
   assign full    = (count_q == FULL_C);
   assign empty   = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/ifetch_queue_imem.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : ifetch_queue_imem
// Brief  : Synchronous-read instruction ROM; output register clears on reset.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
module ifetch_queue_imem
   import ifetch_queue_pkg::*;
#(
   parameter int unsigned      WORD     = DEF_WORD,
   parameter int unsigned      SIZE     = 1024,
   parameter logic [WORD-1:0]  MEM_BASE = WORD'(DEF_MEM_BASE)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    rd_en,
   input  logic [$clog2(SIZE)-1:0] addr,
   output logic [WORD-1:0]         rdata
);

   logic [WORD-1:0] rdata_q;
   logic [WORD-1:0] rdata_d;

   // Word i holds MEM_BASE + i; stands in for the loaded program image.
   always_comb begin
      rdata_d = rdata_q;
      if (rd_en) begin
         rdata_d = MEM_BASE + WORD'(addr);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/ifetch_queue.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : ifetch_queue
// Brief  : Credit-based decoupled fetch stage: PC, one ROM read per cycle, FIFO to decode.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
module ifetch_queue
   import ifetch_queue_pkg::*;
#(
   parameter int unsigned     WORD     = DEF_WORD,
   parameter logic [WORD-1:0] STEP     = WORD'(1),
   parameter int unsigned     SIZE     = 1024,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [WORD-1:0] RESET_PC = WORD'(DEF_RESET_PC)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            PCSrc,
   input  logic [WORD-1:0] BrDest,
   input  logic            out_ready,
   output logic            out_valid,
   output logic [WORD-1:0] IR,
   output logic [WORD-1:0] nPC,
   output logic [WORD-1:0] out_pc,
   output logic [WORD-1:0] fetch_pc
);

   localparam int unsigned  AW = $clog2(SIZE);
   localparam int unsigned  CW = cnt_width(DEPTH);
   localparam int unsigned  EW = 3 * WORD;
   localparam logic [CW:0]  DEPTH_C = DEPTH[CW:0];

   logic [WORD-1:0] pc_q, pc_d;
   logic [WORD-1:0] inflight_pc_q, inflight_pc_d;
   logic            inflight_q, inflight_d;

   logic [WORD-1:0] mem_data;
   logic [EW-1:0]   wr_entry;
   logic [EW-1:0]   head;
   logic [CW-1:0]   count;
   logic            fifo_full;
   logic            fifo_empty;
   logic [CW:0]     credit;
   logic            pop;
   logic            issue;
   logic            enq;

   // Credit counts the outstanding read as occupied so an enqueue never meets a full FIFO.
   always_comb begin
      pop    = ~fifo_empty & out_ready & ~PCSrc;
      credit = {1'b0, count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
      issue  = ~PCSrc & (credit < DEPTH_C);
      enq    = inflight_q & ~PCSrc & ~fifo_full;

      pc_d          = pc_q;
      inflight_d    = issue;
      inflight_pc_d = inflight_pc_q;
      if (PCSrc) begin
         pc_d = BrDest;
      end else if (issue) begin
         pc_d          = pc_q + STEP;
         inflight_pc_d = pc_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q          <= RESET_PC;
         inflight_pc_q <= '0;
         inflight_q    <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         inflight_pc_q <= inflight_pc_d;
         inflight_q    <= inflight_d;
      end
   end

   ifetch_queue_imem #(
      .WORD (WORD),
      .SIZE (SIZE)
   ) u_imem (
      .clk   (clk),
      .rst_n (reset),
      .rd_en (issue),
      .addr  (pc_q[AW-1:0]),
      .rdata (mem_data)
   );

   assign wr_entry = {mem_data, inflight_pc_q, inflight_pc_q + STEP};

   ifetch_queue_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .clr     (PCSrc),
      .wr      (enq),
      .wr_data (wr_entry),
      .rd      (pop),
      .rd_data (head),
      .count   (count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Stale head contents are hidden while the queue is empty.
   always_comb begin
      out_valid = ~fifo_empty;
      IR        = '0;
      out_pc    = '0;
      nPC       = '0;
      if (!fifo_empty) begin
         IR     = head[EW-1 -: WORD];
         out_pc = head[2*WORD-1 -: WORD];
         nPC    = head[WORD-1:0];
      end
   end

   assign fetch_pc = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_queue.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : tb_ifetch_queue
// Brief  : Scoreboarded random + directed bench for the decoupled fetch queue.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_ifetch_queue;

   localparam int unsigned SIZE = 1024;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        PCSrc = 1'b0;
   logic [31:0] BrDest = '0;
   logic        out_ready = 1'b0;
   logic        out_valid;
   logic [31:0] IR, nPC, out_pc, fetch_pc;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] sb [$];
   logic [31:0] exp_pc;

   always #5 clk = ~clk;

   ifetch_queue #(
      .WORD     (32),
      .STEP     (32'd1),
      .SIZE     (SIZE),
      .DEPTH    (4),
      .RESET_PC (32'd0)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .PCSrc     (PCSrc),
      .BrDest    (BrDest),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .IR        (IR),
      .nPC       (nPC),
      .out_pc    (out_pc),
      .fetch_pc  (fetch_pc)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, want);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] pc);
      return 32'hA000_0000 + (pc % SIZE);
   endfunction

   // Program order after a (re)start: start, start+1, ... modulo 2^32.
   task automatic new_segment(input logic [31:0] start);
      sb.delete();
      for (int i = 0; i < 256; i++) sb.push_back(start + 32'(i));
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      #1;
      reset = 1'b0;
      PCSrc = 1'b0;
      new_segment(32'd0);
      #1;
      chk("rst_valid",    {31'd0, out_valid}, 32'd0);
      chk("rst_fetch_pc", fetch_pc, 32'd0);
      chk("rst_ir",       IR,       32'd0);
      chk("rst_npc",      nPC,      32'd0);
      chk("rst_out_pc",   out_pc,   32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      step();
      chk("boot_valid_e1", {31'd0, out_valid}, 32'd0);
      chk("boot_pc_e1",    fetch_pc, 32'd1);
      step();
      chk("boot_valid_e2", {31'd0, out_valid}, 32'd1);
   endtask

   task automatic redirect(input logic [31:0] tgt);
      PCSrc  = 1'b1;
      BrDest = tgt;
      new_segment(tgt);
      step();
      PCSrc  = 1'b0;
      BrDest = $urandom();
      chk("redir_valid_r0", {31'd0, out_valid}, 32'd0);
      chk("redir_pc_r0",    fetch_pc, tgt);
      step();
      chk("redir_valid_r1", {31'd0, out_valid}, 32'd0);
      chk("redir_pc_r1",    fetch_pc, tgt + 32'd1);
      step();
      chk("redir_valid_r2", {31'd0, out_valid}, 32'd1);
      chk("redir_head",     out_pc, tgt);
   endtask

   // Monitor: every accepted handshake must be the next instruction in program order.
   always @(negedge clk) begin
      if (reset) begin
         if (out_valid && out_ready && !PCSrc) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL sb_empty: popped pc %h with nothing expected", out_pc);
            end else begin
               exp_pc = sb.pop_front();
               if (out_pc !== exp_pc || IR !== mem_word(exp_pc) || nPC !== exp_pc + 32'd1) begin
                  bad++;
                  $display("FAIL pop: got pc=%h ir=%h npc=%h expected pc=%h ir=%h npc=%h",
                           out_pc, IR, nPC, exp_pc, mem_word(exp_pc), exp_pc + 32'd1);
               end
            end
         end else if (!out_valid) begin
            total++;
            if ((IR | nPC | out_pc) !== 32'd0) begin
               bad++;
               $display("FAIL mask: got ir=%h npc=%h pc=%h expected all zero", IR, nPC, out_pc);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          since;
      logic [31:0] tgt;
      new_segment(32'd0);

      // Streaming from reset with decode always ready
      out_ready = 1'b1;
      step();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         step();
         chk("t1_no_bubble", {31'd0, out_valid}, 32'd1);
      end

      // Back-pressure: queue saturates and fetch stalls at PC 4
      out_ready = 1'b0;
      do_reset();
      repeat (8) step();
      chk("t2_fetch_stall", fetch_pc, 32'd4);
      chk("t2_head_pc",     out_pc,   32'd0);
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("t2_drain_valid", {31'd0, out_valid}, 32'd1);
      end

      // Redirect mid-stream
      redirect(32'h100);
      repeat (4) step();

      // Redirect while three entries are queued and decode is ready
      out_ready = 1'b0;
      do_reset();
      step();
      step();
      out_ready = 1'b1;
      redirect(32'h40);
      repeat (3) step();

      // Asynchronous reset mid-stream
      repeat (5) step();
      do_reset();
      repeat (4) step();

      // Memory index wrap
      redirect(SIZE - 32'd2);
      repeat (6) step();

      // Randomised traffic
      since = 0;
      for (int c = 0; c < 3000; c++) begin
         out_ready = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 399) == 0) begin
            do_reset();
            since = 0;
         end else if ($urandom_range(0, 29) == 0 || since > 150) begin
            case ($urandom_range(0, 3))
               0:       tgt = $urandom();
               1:       tgt = SIZE - 32'($urandom_range(1, 3));
               2:       tgt = 32'hFFFF_FFFF - 32'($urandom_range(0, 2));
               default: tgt = 32'($urandom_range(0, 2047));
            endcase
            redirect(tgt);
            since = 0;
         end else begin
            step();
            since++;
         end
      end

      out_ready = 1'b1;
      repeat (6) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
